// File: rtl/demultiplexor4.sv
// demultiplexor4: registered 1-to-4 data distributor.
// A word and a 2-bit channel select are accepted over a valid/ready
// handshake. The word is held in a single-entry buffer and presented on one of
// four output channels, and each channel has its own valid/ready handshake.
// Each channel keeps a saturating count of completed transfers.
// Optional feature: define DEMUX_BROADCAST_EN to add the broadcastIn port.
// When broadcastIn is high on accept, the word is delivered to all four
// channels and each channel completes independently.
module demultiplexor4 #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BITS-1:0]       datoInput,
    input  logic [1:0]            selDato,
    input  logic                  validIn,
`ifdef DEMUX_BROADCAST_EN
    input  logic                  broadcastIn,
`endif
    output logic                  readyIn,
    output logic [BITS-1:0]       datoA,
    output logic [BITS-1:0]       datoB,
    output logic [BITS-1:0]       datoC,
    output logic [BITS-1:0]       datoD,
    output logic [3:0]            validOut,
    input  logic [3:0]            readyOut,
    output logic [4*CNT_BITS-1:0] countOut
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t          state_q, state_d;
    logic [BITS-1:0] hold_data_q, hold_data_d;
    logic [1:0]      hold_sel_q, hold_sel_d;
    logic            hold_bcast_q, hold_bcast_d;
    logic [3:0]      pend_q, pend_d;
    logic [3:0]      done;
    logic [3:0]      sel_onehot;
    logic            accept;
    logic            bcast_in;
    logic [BITS-1:0] dato_vec [4];

`ifdef DEMUX_BROADCAST_EN
    assign bcast_in = broadcastIn;
`else
    // Without broadcast support, pend stays one-hot or zero.
    assign bcast_in = 1'b0;
`endif

    // Handshake decode: per-channel completion, input readiness, and accept.
    always_comb begin
        done       = pend_q & readyOut;
        readyIn    = (state_q == EMPTY) || ((pend_q & ~readyOut) == 4'b0000);
        accept     = validIn & readyIn;
        sel_onehot = 4'b0001 << selDato;
    end

    // Next-state logic: a new word loads the buffer, otherwise finished channels drop out.
    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_sel_d   = hold_sel_q;
        hold_bcast_d = hold_bcast_q;
        pend_d       = pend_q & ~readyOut;
        if (accept) begin
            // A drain and an accept in the same cycle keep the block FULL, so there is no bubble.
            hold_data_d  = datoInput;
            hold_sel_d   = selDato;
            hold_bcast_d = bcast_in;
            pend_d       = bcast_in ? 4'b1111 : sel_onehot;
            state_d      = FULL;
        end else if ((state_q == FULL) && (pend_d == 4'b0000)) begin
            state_d = EMPTY;
        end
    end

    // State and holding registers; a word held at reset assertion is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            hold_data_q  <= '0;
            hold_sel_q   <= 2'b00;
            hold_bcast_q <= 1'b0;
            pend_q       <= 4'b0000;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_sel_q   <= hold_sel_d;
            hold_bcast_q <= hold_bcast_d;
            pend_q       <= pend_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [CNT_BITS-1:0] cnt_q, cnt_d;
            logic                ch_sel;

            // Transfer counter: increment on completion and hold at the maximum value.
            always_comb begin
                cnt_d = cnt_q;
                if (done[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Counter register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // A channel drives the held word only while its transfer is pending.
            assign ch_sel       = hold_bcast_q | (hold_sel_q == 2'(gi));
            assign dato_vec[gi] = (pend_q[gi] && ch_sel) ? hold_data_q : '0;
            assign countOut[gi*CNT_BITS +: CNT_BITS] = cnt_q;
        end
    endgenerate

    assign datoA    = dato_vec[0];
    assign datoB    = dato_vec[1];
    assign datoC    = dato_vec[2];
    assign datoD    = dato_vec[3];
    assign validOut = pend_q;

endmodule

// File: tb/tb_demultiplexor4.sv
// Testbench for demultiplexor4. A scoreboard holds one queue of expected
// words per channel. Each accepted word is pushed onto the queue of every
// channel it targets. A monitor samples on the falling clock edge; it checks
// per-channel valid, data and counters against the model and pops entries as
// handshakes complete.
module tb_demultiplexor4;
    localparam int BITS = 32;
    localparam int CB   = 8;
    localparam int CMAX = (1 << CB) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [BITS-1:0] datoInput = '0;
    logic [1:0]      selDato = 2'b00;
    logic            validIn = 1'b0;
    logic            bcast = 1'b0;
    logic            readyIn;
    logic [BITS-1:0] datoA, datoB, datoC, datoD;
    logic [3:0]      validOut;
    logic [3:0]      readyOut = 4'b0000;
    logic [4*CB-1:0] countOut;

    int errors = 0;
    int checks = 0;
    logic [BITS-1:0] exp_q [4][$];
    int mcnt [4];

    always #5 clk = ~clk;

    demultiplexor4 #(.BITS(BITS), .CNT_BITS(CB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .datoInput (datoInput),
        .selDato   (selDato),
        .validIn   (validIn),
`ifdef DEMUX_BROADCAST_EN
        .broadcastIn (bcast),
`endif
        .readyIn   (readyIn),
        .datoA     (datoA),
        .datoB     (datoB),
        .datoC     (datoC),
        .datoD     (datoD),
        .validOut  (validOut),
        .readyOut  (readyOut),
        .countOut  (countOut)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BITS-1:0] dato_of(input int i);
        case (i)
            0: return datoA;
            1: return datoB;
            2: return datoC;
            default: return datoD;
        endcase
    endfunction

    function automatic logic [4*CB-1:0] pack_cnt();
        logic [4*CB-1:0] p;
        for (int i = 0; i < 4; i++) p[i*CB +: CB] = CB'(mcnt[i]);
        return p;
    endfunction

    function automatic logic bcast_eff();
`ifdef DEMUX_BROADCAST_EN
        return bcast;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor and scoreboard: judge the cycle just before the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count", 64'(countOut), 64'(pack_cnt()));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("valid%0d", i), 64'(validOut[i]), 64'(exp_q[i].size() != 0));
                if (!validOut[i]) begin
                    check($sformatf("idle_dato%0d", i), 64'(dato_of(i)), 64'd0);
                end else if (readyOut[i]) begin
                    if (exp_q[i].size() != 0)
                        check($sformatf("dato%0d", i), 64'(dato_of(i)), 64'(exp_q[i].pop_front()));
                    if (mcnt[i] < CMAX) mcnt[i]++;
                end
            end
            if (validIn && readyIn) begin
                if (bcast_eff()) begin
                    for (int i = 0; i < 4; i++) exp_q[i].push_back(datoInput);
                end else begin
                    exp_q[selDato].push_back(datoInput);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            mcnt[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mcnt[i] = 0;

        // 1. Reset state
        tick();
        tick();
        check("rst_readyIn", 64'(readyIn), 64'd1);
        check("rst_validOut", 64'(validOut), 64'd0);
        check("rst_datos", 64'(datoA | datoB | datoC | datoD), 64'd0);
        check("rst_count", 64'(countOut), 64'd0);
        rst_n = 1'b1;
        tick();
        // Mid-transfer reset
        datoInput = 32'h12345678; selDato = 2'd1; validIn = 1'b1; readyOut = 4'b0000;
        tick();
        validIn = 1'b0;
        check("mid_validOut", 64'(validOut), 64'b0010);
        check("mid_datoB", 64'(datoB), 64'h12345678);
        tick();
        assert_reset();
        #1;
        check("mid_rst_validOut", 64'(validOut), 64'd0);
        check("mid_rst_datoB", 64'(datoB), 64'd0);
        check("mid_rst_countB", 64'(countOut[1*CB +: CB]), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 2. Basic delivery
        datoInput = 32'hDEADBEEF; selDato = 2'd2; validIn = 1'b1; readyOut = 4'b0100;
        tick();
        validIn = 1'b0;
        check("basic_validOut", 64'(validOut), 64'b0100);
        check("basic_datoC", 64'(datoC), 64'hDEADBEEF);
        check("basic_others", 64'(datoA | datoB | datoD), 64'd0);
        tick();
        check("basic_validOut_after", 64'(validOut), 64'd0);
        check("basic_countC", 64'(countOut[2*CB +: CB]), 64'd1);

        // 3. Backpressure
        readyOut = 4'b0000;
        datoInput = 32'h11112222; selDato = 2'd1; validIn = 1'b1;
        tick();
        datoInput = 32'hA5A5A5A5; selDato = 2'd3;
        for (int k = 0; k < 3; k++) begin
            check("bp_readyIn", 64'(readyIn), 64'd0);
            check("bp_datoB", 64'(datoB), 64'h11112222);
            check("bp_validOut", 64'(validOut), 64'b0010);
            tick();
        end
        readyOut = 4'b0010;
        #1;
        check("bp_release_readyIn", 64'(readyIn), 64'd1);
        tick();
        validIn = 1'b0;
        check("bp_validOut_D", 64'(validOut), 64'b1000);
        check("bp_datoD", 64'(datoD), 64'hA5A5A5A5);
        readyOut = 4'b1000;
        tick();

        // 4. Wrong-channel ready
        readyOut = 4'b0000;
        datoInput = 32'hCAFEF00D; selDato = 2'd0; validIn = 1'b1;
        tick();
        validIn = 1'b0;
        readyOut = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("wc_validOut", 64'(validOut), 64'b0001);
            check("wc_readyIn", 64'(readyIn), 64'd0);
            check("wc_count", 64'(countOut), 64'(pack_cnt()));
            tick();
        end
        readyOut = 4'b0001;
        tick();

        // 5. Saturation with back-to-back words
        readyOut = 4'b1000; selDato = 2'd3; validIn = 1'b1;
        for (int k = 0; k < 300; k++) begin
            datoInput = $urandom;
            #1;
            check("sat_readyIn", 64'(readyIn), 64'd1);
            tick();
            check("sat_validOut", 64'(validOut), 64'b1000);
        end
        validIn = 1'b0;
        tick();
        tick();
        check("sat_countD", 64'(countOut[3*CB +: CB]), 64'd255);

`ifdef DEMUX_BROADCAST_EN
        // 6. Broadcast
        assert_reset();
        readyOut = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        datoInput = 32'h0F0F0F0F; bcast = 1'b1; validIn = 1'b1;
        tick();
        validIn = 1'b0; bcast = 1'b0;
        check("bc_validOut_all", 64'(validOut), 64'b1111);
        check("bc_datos", 64'(datoA & datoB & datoC & datoD), 64'h0F0F0F0F);
        readyOut = 4'b0101;
        tick();
        check("bc_pend_1010", 64'(validOut), 64'b1010);
        check("bc_readyIn", 64'(readyIn), 64'd0);
        tick();
        check("bc_pend_hold", 64'(validOut), 64'b1010);
        readyOut = 4'b1111;
        tick();
        check("bc_pend_clear", 64'(validOut), 64'd0);
        check("bc_counts", 64'(countOut), 64'h01010101);
`endif

        // Randomised traffic against the scoreboard
        for (int k = 0; k < 500; k++) begin
            validIn   = 1'($urandom_range(0, 1));
            datoInput = $urandom;
            selDato   = 2'($urandom_range(0, 3));
            readyOut  = 4'($urandom_range(0, 15));
            bcast     = ($urandom_range(0, 7) == 0);
            tick();
        end
        validIn = 1'b0; bcast = 1'b0; readyOut = 4'b1111;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++)
            check($sformatf("drain_q%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
